// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Definitions shared by the UART receive and transmit paths:
//               FSM state encoding, parity-type constants, the default
//               payload width and a three-input majority vote helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Receiver FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Values of the parity-type select input
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Two-out-of-three vote used to reject a single corrupted oversample
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : Bit-period timing for the UART receiver. An edge counter runs
//               0..prescale-1 across each bit while the FSM is active; the
//               synchronized line is sampled at prescale/2-1, prescale/2 and
//               prescale/2+1 and the majority of the three is latched.
// Ports       : clk_i         - clock, rising edge
//               rst_i         - synchronous active-high reset
//               rx_s_i        - synchronized serial line
//               prescale_i    - oversampling ratio (8, 16 or 32)
//               run_i         - FSM outside IDLE; counter advances
//               seed_one_i    - while not running, preload the counter with
//                               1 instead of 0
//               edge_cnt_o    - position within the current bit
//               sampled_bit_o - majority-voted value of the current bit
//               bit_done_o    - sampled_bit_o freshly updated this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_s_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  run_i,
  input  logic                  seed_one_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic                  sampled_bit_o,
  output logic                  bit_done_o
);

  import uart_pkg::*;

  logic [PRESCALE_W-1:0] edge_cnt_q;
  logic [PRESCALE_W-1:0] edge_cnt_d;
  logic                  s0_q;
  logic                  s1_q;
  logic                  bit_q;

  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last_tick;

  assign half      = {1'b0, prescale_i[PRESCALE_W-1:1]};
  assign last_tick = prescale_i - PRESCALE_W'(1);

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (!run_i) begin
      edge_cnt_d = seed_one_i ? PRESCALE_W'(1) : '0;
    end else if (edge_cnt_q == last_tick) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      edge_cnt_q <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      if (run_i) begin
        if (edge_cnt_q == half - PRESCALE_W'(1)) s0_q <= rx_s_i;
        if (edge_cnt_q == half)                  s1_q <= rx_s_i;
        // Third sample is taken directly from the line and voted at once
        if (edge_cnt_q == half + PRESCALE_W'(1)) bit_q <= maj3(s0_q, s1_q, rx_s_i);
      end
    end
  end

  assign edge_cnt_o    = edge_cnt_q;
  assign sampled_bit_o = bit_q;
  // The vote lands at the end of tick half+1, so it is readable on half+2;
  // for the smallest ratio (8) that is still before the last tick.
  assign bit_done_o    = run_i && (edge_cnt_q == half + PRESCALE_W'(2));

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : UART receiver. Synchronizes RX_IN, oversamples each bit by a
//               run-time prescale with a 3-sample majority vote, assembles an
//               LSB-first payload, checks optional parity and the stop bit and
//               reports one result strobe per frame.
// Ports       : CLK        - clock, rising edge
//               RST        - synchronous active-high reset
//               RX_IN      - asynchronous serial input, idle high
//               Prescale   - oversampling ratio (8, 16, 32)
//               PAR_EN     - parity bit present after the data bits
//               PAR_TYP    - 0 even, 1 odd parity
//               P_DATA     - last good payload, updated with data_valid
//               data_valid - one-cycle strobe, frame good
//               par_err    - one-cycle strobe, parity mismatch
//               stp_err    - one-cycle strobe, stop bit sampled low
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Synchronizer and one-cycle history of the synchronized line
  logic rx_meta_q;
  logic rx_s_q;
  logic rx_prev_q;

  logic [2:0]            state_q,    state_d;
  logic [BC_W-1:0]       bit_cnt_q,  bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q,    shreg_d;
  logic                  par_bad_q,  par_bad_d;
  logic [DATA_WIDTH-1:0] p_data_q,   p_data_d;
  logic                  dv_q,       dv_d;
  logic                  pe_q,       pe_d;
  logic                  se_q,       se_d;

  logic [PRESCALE_W-1:0] edge_cnt;
  logic                  sampled_bit;
  logic                  bit_done;
  logic                  edge_last;
  logic                  par_expected;

  // A start bit that follows a stop bit with no gap is already one cycle old
  // when the FSM reaches IDLE (the STOP state consumed the first low cycle),
  // so the bit clock is resumed one tick in to stay aligned with the line.
  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk_i         (CLK),
    .rst_i         (RST),
    .rx_s_i        (rx_s_q),
    .prescale_i    (Prescale),
    .run_i         (state_q != ST_IDLE),
    .seed_one_i    (!rx_prev_q),
    .edge_cnt_o    (edge_cnt),
    .sampled_bit_o (sampled_bit),
    .bit_done_o    (bit_done)
  );

  assign edge_last    = (edge_cnt == Prescale - PRESCALE_W'(1));
  assign par_expected = (^shreg_q) ^ (PAR_TYP == PAR_ODD);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_bad_d = par_bad_q;
    p_data_d  = p_data_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end
      end

      ST_START: begin
        // A start bit that votes high was a glitch: drop it silently
        if (edge_last) state_d = sampled_bit ? ST_IDLE : ST_DATA;
      end

      ST_DATA: begin
        if (bit_done) shreg_d = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
        if (edge_last) begin
          if (bit_cnt_q == BC_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (bit_done)  par_bad_d = (sampled_bit != par_expected);
        if (edge_last) state_d   = ST_STOP;
      end

      ST_STOP: begin
        if (edge_last) begin
          state_d = ST_IDLE;
          // Stop-bit failure hides any parity result for the same frame
          if (!sampled_bit) begin
            se_d = 1'b1;
          end else if (par_bad_q) begin
            pe_d = 1'b1;
          end else begin
            dv_d     = 1'b1;
            p_data_d = shreg_q;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_bad_q <= 1'b0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_bad_q <= par_bad_d;
      p_data_q  <= p_data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Self-checking bench for uart_rx_core. Frames are driven bit
//               by bit on RX_IN; a reference model predicts, per frame, the
//               result strobe, the visible P_DATA and the cycle the strobe
//               appears on, and compares against a log of observed strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

  localparam int DW = 8;
  localparam int PW = 6;

  localparam int K_VALID = 1;
  localparam int K_PAR   = 2;
  localparam int K_STP   = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  uart_rx_core #(
    .DATA_WIDTH (DW),
    .PRESCALE_W (PW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observed strobes
  int ev_kind[$];
  int ev_data[$];
  int ev_cyc[$];

  always @(negedge CLK) begin
    if (data_valid || par_err || stp_err) begin
      chk("one_strobe", $countones({data_valid, par_err, stp_err}), 1);
      ev_kind.push_back(data_valid ? K_VALID : (par_err ? K_PAR : K_STP));
      ev_data.push_back(int'(P_DATA));
      ev_cyc.push_back(cyc);
    end
  end

  // Reference model state and predictions
  logic [DW-1:0] last_good = '0;
  int exp_kind[$];
  int exp_data[$];
  int exp_cyc[$];

  // Frame outcome from the line contents alone
  function automatic int frame_result(input logic [DW-1:0] d, input bit pen,
                                      input bit ptyp, input bit pbit, input bit stopb);
    int ones;
    if (!stopb) return K_STP;
    ones = $countones(d) + int'(pbit);
    if (pen && ((ones % 2) != int'(ptyp))) return K_PAR;
    return K_VALID;
  endfunction

  // Drive one frame; every call starts and ends 1 ns after a rising edge.
  // glitch_bit selects a frame bit that gets one inverted cycle (-1: none).
  task automatic send_frame(input logic [DW-1:0] d, input bit pbit, input bit stopb,
                            input int glitch_bit);
    int p;
    int n;
    int k;
    logic [10:0] bits;
    p = int'(Prescale);
    n = 10 + int'(PAR_EN);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1 + i] = d[i];
    if (PAR_EN) bits[9] = pbit;
    bits[n - 1] = stopb;

    k = frame_result(d, PAR_EN, PAR_TYP, pbit, stopb);
    exp_kind.push_back(k);
    if (k == K_VALID) last_good = d;
    exp_data.push_back(int'(last_good));
    // Two synchronizer cycles plus one IDLE detection cycle after the frame
    exp_cyc.push_back(cyc + n * p + 3);

    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < p; j++) begin
        RX_IN = bits[i] ^ ((i == glitch_bit) && (j == p / 2 + 1));
        @(posedge CLK);
        #1;
      end
    end
  endtask

  task automatic idle_and_check(input int gap);
    int k_e;
    int d_e;
    int c_e;
    RX_IN = 1'b1;
    repeat (gap) @(posedge CLK);
    #1;
    chk("strobe_count", ev_kind.size(), exp_kind.size());
    while (exp_kind.size() > 0) begin
      k_e = exp_kind.pop_front();
      d_e = exp_data.pop_front();
      c_e = exp_cyc.pop_front();
      if (ev_kind.size() > 0) begin
        chk("strobe_kind",  ev_kind.pop_front(), k_e);
        chk("p_data",       ev_data.pop_front(), d_e);
        chk("strobe_cycle", ev_cyc.pop_front(),  c_e);
      end
    end
    ev_kind.delete();
    ev_data.delete();
    ev_cyc.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pdata"}, P_DATA, 0);
    chk({tag, "_dv"},    data_valid, 0);
    chk({tag, "_pe"},    par_err, 0);
    chk({tag, "_se"},    stp_err, 0);
  endtask

  initial begin
    int p;
    int nf;
    int err;
    logic [DW-1:0] d;
    logic good_par;

    RST      = 1'b1;
    RX_IN    = 1'b1;
    Prescale = PW'(8);
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST = 1'b0;
    idle_and_check(10);

    // Prescale 8, no parity, 0xA5
    Prescale = PW'(8);  PAR_EN = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    idle_and_check(30);

    // Prescale 16, even parity: correct then wrong parity bit
    Prescale = PW'(16); PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    idle_and_check(50);
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    idle_and_check(50);

    // Prescale 32: stop bit low together with bad parity
    Prescale = PW'(32);
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    idle_and_check(80);

    // Short start pulse is rejected, then a normal frame
    Prescale = PW'(16); PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    idle_and_check(60);
    send_frame(8'h55, 1'b0, 1'b1, -1);
    idle_and_check(50);

    // One-cycle glitch in the middle of data bit 0
    send_frame(8'h81, 1'b0, 1'b1, 1);
    idle_and_check(50);

    // Back-to-back frames with no idle gap
    send_frame(8'h12, 1'b0, 1'b1, -1);
    send_frame(8'h34, 1'b0, 1'b1, -1);
    idle_and_check(50);

    // Reset in the middle of a second frame
    send_frame(8'h12, 1'b0, 1'b1, -1);
    RX_IN = 1'b0;
    repeat (16) begin @(posedge CLK); #1; end
    RX_IN = 1'b1;
    repeat (24) begin @(posedge CLK); #1; end
    RX_IN = 1'b0;
    repeat (16) begin @(posedge CLK); #1; end
    RST   = 1'b1;
    RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("mid_reset");
    RST = 1'b0;
    last_good = '0;
    idle_and_check(220);

    // Randomized frames; configuration changes only while idle
    for (int f = 0; f < 16; f++) begin
      case ($urandom_range(2, 0))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      Prescale = PW'(p);
      PAR_EN   = 1'($urandom_range(1, 0));
      PAR_TYP  = 1'($urandom_range(1, 0));
      nf = $urandom_range(2, 1);
      for (int m = 0; m < nf; m++) begin
        d        = DW'($urandom);
        err      = $urandom_range(3, 0);
        good_par = (^d) ^ PAR_TYP;
        send_frame(d, (err == 1) ? ~good_par : good_par, (err == 0) ? 1'b0 : 1'b1, -1);
      end
      idle_and_check(2 * p + 8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
